wb_bus_reader: RTL and testbench
================================

# wb_bus_reader

Writeback-stage bus reader for the pipelined CPU. It sequences reads of up to NrOfSources tri-stateable pipeline result registers that share one NrOfBits-wide bus. For each source it drives that register's `cs` low, waits a settle tick, captures the bus, and issues one register-file write. Only one source is enabled onto the bus at any time, so no contention is possible.

## Interface
- NrOfBits, 32, data width of the shared bus and the register file.
- NrOfSources, 4, number of tri-state sources on the bus (≥1).
- RegAddrBits, 5, register-file address width.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high.
- Tick  in  1  global clock-enable; all state advances only on Clock edges with Tick=1.
- Start  in  1  begin a read sweep; sampled in IDLE only.
- SrcMask  in  NrOfSources  bit i=1: source i holds valid data; latched at Start.
- DestAddr  in  NrOfSources*RegAddrBits  slice i is the RF address for source i; latched at Start.
- Bus  in  NrOfBits  shared tri-state result bus.
- cs  out  NrOfSources  per-source output disable; 1 = high-Z, 0 = drive bus.
- RfWe  out  1  register-file write enable.
- RfAddr  out  RegAddrBits  write address.
- RfData  out  NrOfBits  write data.
- Busy  out  1  high from the Start acceptance until the DONE state completes.
- Done  out  1  one-tick pulse at the end of a sweep.

## Operation
- Reset values: cs all ones, RfWe 0, RfAddr 0, RfData 0, Busy 0, Done 0, state IDLE, index 0.
- States: IDLE, SELECT, SAMPLE, WRITE, DONE.
- IDLE: when Start=1 and Tick=1, latch SrcMask/DestAddr, set index to the first source, and go to SELECT. With SKIP enabled and a latched mask of 0, go directly to DONE.
- SELECT: cs[index]=0 if mask[index]=1; otherwise all cs=1. This is the settle tick. Next state is SAMPLE.
- SAMPLE: cs unchanged from SELECT. On exit, capture Bus into the data register. Next state is WRITE.
- WRITE: all cs=1. RfAddr = DestAddr slice[index], RfData = captured value, RfWe = mask[index] & Tick. If another source remains, advance index and go to SELECT; otherwise go to DONE.
- DONE: Done=1 for one tick, then IDLE. Busy drops on entry to IDLE.
- Start while Busy=1 is ignored and not queued.
- At most one cs bit is 0 at any instant. cs is never 0 in WRITE, DONE or IDLE.
- Tick=0 freezes all state, cs, RfAddr and RfData. RfWe is forced to 0.
- Reset mid-sweep: all cs go to 1 and RfWe goes to 0 immediately and asynchronously. The sweep is abandoned with no Done pulse.

## Timing
- Tick held at 1: Start accepted at edge 0, SELECT in cycle 1, SAMPLE in cycle 2, WRITE in cycle 3. Each visited source costs 3 ticks. DONE follows the last WRITE by 1 tick.
- Latency from Start to the first RfWe is 3 ticks. Captured data is Bus as it stands at the end of SAMPLE, i.e. 2 ticks after cs falls.
- Full mask, no skip: 3*NrOfSources + 1 ticks from Start to Done.
- All outputs are registered except RfWe, which is gated by Tick.

## Configuration
- WB_BUS_READER_SKIP_EN defined:
  - Masked-off sources take 0 ticks; the index jumps to the next set mask bit using a priority scan.
  - An all-zero mask gives Done 1 tick after Start.
  - Sweep length is 3*popcount(mask) + 1 ticks.
- Undefined:
  - Every index 0..NrOfSources-1 is visited.
  - A masked source spends 3 ticks with cs all ones and RfWe 0.
  - Sweep length is fixed at 3*NrOfSources + 1 ticks.

## Structure
- Package wb_bus_reader_pkg holds the state enum (IDLE, SELECT, SAMPLE, WRITE, DONE) and the CS_ALL_OFF constant.
- Sub-module wb_bus_reader_next_src: combinational priority finder. Given the latched mask and the current index, it returns the next set index and a "none left" flag. It is used in both configurations; without SKIP it returns index+1.

## Test plan
- Reset, then NrOfSources=4, mask 4'b1111, DestAddr {3,2,1,0}, each source modelled driving 0xA0+i when its cs=0:
  - RF writes (addr,data) are (0,0xA0), (1,0xA1), (2,0xA2), (3,0xA3) at ticks 3, 6, 9 and 12.
  - Done pulses at tick 13.
- Mask 4'b0101:
  - With SKIP: writes only to sources 0 and 2; Done at tick 7.
  - Without SKIP: same writes, Done at tick 13, cs never low for sources 1 and 3.
- Tick toggling 1,0 during a sweep: state holds on Tick=0, RfWe stays 0 on Tick=0 ticks, and the write sequence is the same as with Tick held at 1.
- Start pulsed again while Busy: no effect, and exactly one Done pulse.
- Reset asserted while in SAMPLE for source 1: cs goes to 4'b1111 and RfWe to 0 in the same cycle, no Done; a following Start runs a clean sweep.
- Contention check across all sweeps: the bench asserts that popcount(~cs) ≤ 1 at every cycle.

Source files
------------

// File: rtl/wb_bus_reader_pkg.sv
// wb_bus_reader_pkg: shared types and constants for the writeback bus reader.
// Holds the sweep state enum, the all-sources-released cs pattern and an index-width helper.
package wb_bus_reader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        SAMPLE,
        WRITE,
        DONE
    } state_e;

    // Wide enough for any sensible source count; users slice the low bits.
    localparam int                        CS_MAX_SOURCES = 64;
    localparam logic [CS_MAX_SOURCES-1:0] CS_ALL_OFF     = '1;

    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_bus_reader_next_src.sv
// wb_bus_reader_next_src: picks the next source to visit at or after 'base'.
// Ports: mask (latched valid mask), base (first candidate index),
//        next_idx, hit (next source holds data), none_left (sweep exhausted).
// Macro WB_BUS_READER_SKIP_EN: priority-scan to the next set mask bit.
module wb_bus_reader_next_src
    import wb_bus_reader_pkg::*;
#(
    parameter int NrOfSources = 4,
    parameter int IdxBits     = 2
) (
    input  logic [NrOfSources-1:0] mask,
    input  logic [IdxBits:0]       base,
    output logic [IdxBits-1:0]     next_idx,
    output logic                   hit,
    output logic                   none_left
);

`ifdef WB_BUS_READER_SKIP_EN
    // Descending loop so the lowest qualifying index wins.
    always_comb begin
        next_idx  = '0;
        none_left = 1'b1;
        for (int i = NrOfSources - 1; i >= 0; i--) begin
            if (mask[i] && ((IdxBits+1)'(i) >= base)) begin
                next_idx  = IdxBits'(i);
                none_left = 1'b0;
            end
        end
        hit = !none_left;
    end
`else
    // Every index is visited; a masked one is walked with the bus idle.
    always_comb begin
        next_idx  = base[IdxBits-1:0];
        none_left = (base >= (IdxBits+1)'(NrOfSources));
        hit       = !none_left && mask[next_idx];
    end
`endif

endmodule

// File: rtl/wb_bus_reader.sv
// wb_bus_reader: sweeps tri-state result registers over one shared bus into the RF.
// Ports: Clock, Reset (async, high), Tick (enable), Start, SrcMask, DestAddr, Bus in;
//        cs (0 = drive), RfWe/RfAddr/RfData (RF write), Busy, Done out.
// Macro WB_BUS_READER_SKIP_EN: masked-off sources cost no ticks.
module wb_bus_reader
    import wb_bus_reader_pkg::*;
#(
    parameter int NrOfBits    = 32,
    parameter int NrOfSources = 4,
    parameter int RegAddrBits = 5
) (
    input  logic                               Clock,
    input  logic                               Reset,
    input  logic                               Tick,
    input  logic                               Start,
    input  logic [NrOfSources-1:0]             SrcMask,
    input  logic [NrOfSources*RegAddrBits-1:0] DestAddr,
    input  logic [NrOfBits-1:0]                Bus,
    output logic [NrOfSources-1:0]             cs,
    output logic                               RfWe,
    output logic [RegAddrBits-1:0]             RfAddr,
    output logic [NrOfBits-1:0]                RfData,
    output logic                               Busy,
    output logic                               Done
);

    localparam int IdxBits = idx_bits(NrOfSources);
    localparam logic [NrOfSources-1:0] CsOff =
        CS_ALL_OFF[NrOfSources-1:0];

    state_e                             state_q, state_d;
    logic [IdxBits-1:0]                 idx_q, idx_d;
    logic [NrOfSources-1:0]             mask_q, mask_d;
    logic [NrOfSources*RegAddrBits-1:0] dest_q, dest_d;
    logic [NrOfSources-1:0]             cs_d, cs_sel;
    logic [RegAddrBits-1:0]             addr_d;
    logic [NrOfBits-1:0]                data_d;

    logic [NrOfSources-1:0] scan_mask;
    logic [IdxBits:0]       base;
    logic [IdxBits-1:0]     next_idx;
    logic                   hit;
    logic                   none_left;

    // In IDLE the mask is not latched yet, so scan the live input.
    assign scan_mask = (state_q == IDLE) ? SrcMask : mask_q;
    assign base      = (state_q == WRITE)
                     ? ({1'b0, idx_q} + (IdxBits+1)'(1))
                     : '0;

    wb_bus_reader_next_src #(
        .NrOfSources (NrOfSources),
        .IdxBits     (IdxBits)
    ) u_next_src (
        .mask      (scan_mask),
        .base      (base),
        .next_idx  (next_idx),
        .hit       (hit),
        .none_left (none_left)
    );

    assign cs_sel = ~(NrOfSources'(1) << next_idx);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        dest_d  = dest_q;
        cs_d    = cs;
        addr_d  = RfAddr;
        data_d  = RfData;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    mask_d = SrcMask;
                    dest_d = DestAddr;
                    if (none_left) begin
                        state_d = DONE;
                        idx_d   = '0;
                    end else begin
                        state_d = SELECT;
                        idx_d   = next_idx;
                        cs_d    = hit ? cs_sel : CsOff;
                    end
                end
            end
            SELECT: begin
                state_d = SAMPLE;
            end
            SAMPLE: begin
                state_d = WRITE;
                data_d  = Bus;
                addr_d  = dest_q[int'(idx_q)*RegAddrBits +: RegAddrBits];
                cs_d    = CsOff;
            end
            WRITE: begin
                if (none_left) begin
                    state_d = DONE;
                end else begin
                    state_d = SELECT;
                    idx_d   = next_idx;
                    cs_d    = hit ? cs_sel : CsOff;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cs_d    = CsOff;
            end
        endcase
    end

    // Registered state: an asserted Reset drops cs and RfWe at once.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            mask_q  <= '0;
            dest_q  <= '0;
            cs      <= CsOff;
            RfAddr  <= '0;
            RfData  <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else if (Tick) begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            dest_q  <= dest_d;
            cs      <= cs_d;
            RfAddr  <= addr_d;
            RfData  <= data_d;
            Busy    <= (state_d != IDLE);
            Done    <= (state_d == DONE);
        end
    end

    assign RfWe = (state_q == WRITE) && mask_q[idx_q] && Tick;

endmodule

// File: tb/tb_wb_bus_reader.sv
// tb_wb_bus_reader: self-checking bench for wb_bus_reader.
// Directed table, hand-written reset/Start corner cases, random sweeps vs a model.
module tb_wb_bus_reader;

    localparam int NB = 32;
    localparam int NS = 4;
    localparam int AB = 5;

    logic             Clock = 1'b0;
    logic             Reset;
    logic             Tick;
    logic             Start;
    logic [NS-1:0]    SrcMask;
    logic [NS*AB-1:0] DestAddr;
    logic [NB-1:0]    Bus;
    logic [NS-1:0]    cs;
    logic             RfWe;
    logic [AB-1:0]    RfAddr;
    logic [NB-1:0]    RfData;
    logic             Busy;
    logic             Done;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    logic [NB-1:0] src_val [NS];

    typedef struct {
        logic [AB-1:0] addr;
        logic [NB-1:0] data;
        int            k;
    } wr_t;

    typedef struct {
        logic [NS-1:0] mask;
        int            tmode;
        bit            again;
        int            exp_done;
    } vec_t;

    wr_t  exp_q[$];
    wr_t  act_q[$];
    vec_t vt[6];

    wb_bus_reader #(
        .NrOfBits    (NB),
        .NrOfSources (NS),
        .RegAddrBits (AB)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Tick     (Tick),
        .Start    (Start),
        .SrcMask  (SrcMask),
        .DestAddr (DestAddr),
        .Bus      (Bus),
        .cs       (cs),
        .RfWe     (RfWe),
        .RfAddr   (RfAddr),
        .RfData   (RfData),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 Clock = ~Clock;

    // Sources: whichever has cs low drives its value; idle bus reads a marker.
    always_comb begin
        Bus = 32'hDEAD_BEEF;
        for (int i = 0; i < NS; i++)
            if (!cs[i]) Bus = src_val[i];
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge Clock) begin
        if (mon_en && !Reset)
            check("contention", 64'($countones(~cs) <= 1), 64'd1);
    end

    // Expected writes from the sweep rules: source i with data is written
    // at tick 3*(pos+1), pos being its rank among set bits (skip) or i.
    task automatic model(input logic [NS-1:0] m, input logic [NS*AB-1:0] d,
                         output int done_k);
        int rank;
        int pos;
        rank = 0;
        exp_q = {};
        for (int i = 0; i < NS; i++) begin
            if (m[i]) begin
`ifdef WB_BUS_READER_SKIP_EN
                pos = rank;
`else
                pos = i;
`endif
                exp_q.push_back('{d[i*AB +: AB], src_val[i], 3*(pos+1)});
                rank++;
            end
        end
`ifdef WB_BUS_READER_SKIP_EN
        done_k = 3*rank + 1;
`else
        done_k = 3*NS + 1;
`endif
    endtask

    task automatic run_sweep(input logic [NS-1:0] m,
                             input logic [NS*AB-1:0] d,
                             input int tmode, input bit again,
                             input int exp_done);
        int k;
        int cyc;
        int done_cnt;
        int done_k;
        int unused_k;
        logic [NS-1:0] low_seen;
        model(m, d, unused_k);
        act_q = {};
        @(negedge Clock);
        SrcMask = m;
        DestAddr = d;
        Start = 1'b1;
        Tick = 1'b1;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        SrcMask = NS'($urandom);
        DestAddr = (NS*AB)'($urandom);
        k = 1;
        cyc = 0;
        done_cnt = 0;
        done_k = -1;
        low_seen = '0;
        while (k <= exp_done + 1 && cyc < 200) begin
            @(negedge Clock);
            case (tmode)
                0: Tick = 1'b1;
                1: Tick = (cyc % 2 == 0);
                default: Tick = 1'($urandom_range(0, 1));
            endcase
            Start = again && (k == 5 || k == exp_done);
            #1;
            if (cyc == 0) check("busy_first", 64'(Busy), 64'd1);
            low_seen |= ~cs;
            if (!Tick) check("rfwe_tick0", 64'(RfWe), 64'd0);
            if (Tick && RfWe) act_q.push_back('{RfAddr, RfData, k});
            if (Tick && Done) begin
                done_cnt++;
                done_k = k;
            end
            @(posedge Clock);
            if (Tick) k++;
            cyc++;
        end
        #1;
        Start = 1'b0;
        check("timeout", 64'(cyc < 200), 64'd1);
        check("busy_after", 64'(Busy), 64'd0);
        check("done_count", 64'(done_cnt), 64'd1);
        check("done_tick", 64'(done_k), 64'(exp_done));
        check("cs_low_set", 64'(low_seen), 64'(m));
        check("n_writes", 64'(act_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("wr%0d_addr", i), 64'(act_q[i].addr),
                  64'(exp_q[i].addr));
            check($sformatf("wr%0d_data", i), 64'(act_q[i].data),
                  64'(exp_q[i].data));
            check($sformatf("wr%0d_tick", i), 64'(act_q[i].k),
                  64'(exp_q[i].k));
        end
    endtask

    initial begin
        logic [NS*AB-1:0] d0;
        int dseen;
        int ed;
        Reset = 1'b1;
        Tick = 1'b0;
        Start = 1'b0;
        SrcMask = '0;
        DestAddr = '0;
        for (int i = 0; i < NS; i++) src_val[i] = 32'hA0 + 32'(i);
        d0 = {5'd3, 5'd2, 5'd1, 5'd0};

        vt[0] = '{4'b1111, 0, 1'b0, 13};
`ifdef WB_BUS_READER_SKIP_EN
        vt[1] = '{4'b0101, 0, 1'b0, 7};
        vt[4] = '{4'b0000, 0, 1'b0, 1};
        vt[5] = '{4'b1000, 2, 1'b0, 4};
`else
        vt[1] = '{4'b0101, 0, 1'b0, 13};
        vt[4] = '{4'b0000, 0, 1'b0, 13};
        vt[5] = '{4'b1000, 2, 1'b0, 13};
`endif
        vt[2] = '{4'b1111, 1, 1'b0, 13};
        vt[3] = '{4'b1111, 0, 1'b1, 13};

        repeat (3) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        check("rst_cs", 64'(cs), 64'hF);
        check("rst_rfwe", 64'(RfWe), 64'd0);
        check("rst_addr", 64'(RfAddr), 64'd0);
        check("rst_data", 64'(RfData), 64'd0);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        mon_en = 1'b1;

        for (int v = 0; v < 6; v++)
            run_sweep(vt[v].mask, d0, vt[v].tmode, vt[v].again,
                      vt[v].exp_done);

        // Reset while source 1 is in SAMPLE.
        @(negedge Clock);
        SrcMask = 4'b1111;
        DestAddr = d0;
        Start = 1'b1;
        Tick = 1'b1;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        repeat (4) @(posedge Clock);
        @(negedge Clock);
        #1;
        check("sample1_cs", 64'(cs), 64'b1101);
        Reset = 1'b1;
        #1;
        check("mid_rst_cs", 64'(cs), 64'hF);
        check("mid_rst_rfwe", 64'(RfWe), 64'd0);
        @(negedge Clock);
        Reset = 1'b0;
        dseen = 0;
        repeat (20) begin
            @(negedge Clock);
            #1;
            if (Done) dseen++;
        end
        check("no_done_after_rst", 64'(dseen), 64'd0);
        run_sweep(4'b1111, d0, 0, 1'b0, 13);

        for (int r = 0; r < 24; r++) begin
            logic [NS-1:0]    m;
            logic [NS*AB-1:0] d;
            for (int i = 0; i < NS; i++) src_val[i] = $urandom;
            m = NS'($urandom);
            d = (NS*AB)'($urandom);
            model(m, d, ed);
            run_sweep(m, d, int'($urandom_range(0, 2)),
                      1'($urandom_range(0, 1)), ed);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
